nano_mem_arbiter: RTL and testbench
===================================

Name: nano_mem_arbiter

Overview:
- Shares one single-port 256x16 synchronous-read memory between two requesters.
- Port 0 is the NanoCPU memory interface. Port 1 is a host/loader port used for program download and result readback.
- Uses round-robin arbitration with a req/gnt handshake and one access issued per grant.
- Sits between the requesters and the memory. The memory returns read data one cycle after its ce.

Parameters:
AW, 8, address width (256 words)
DW, 16, data width

Ports:
ck  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req0  in  1  port 0 access request; held until gnt0
we0  in  1  port 0 write enable (1=write, 0=read); stable while req0
addr0  in  AW  port 0 address; stable while req0
wdata0  in  DW  port 0 write data; stable while req0
gnt0  out  1  one-cycle pulse: port 0 access issued to memory this cycle
rvalid0  out  1  one-cycle pulse: rdata0 carries port 0 read result
rdata0  out  DW  read data to port 0
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
mem_ce  out  1  memory chip enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after a read ce

Behaviour:
- Interface: one clock ck; rst is synchronous and active-high, sampled on the rising edge of ck.
- Reset values: all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie; rvalid pipeline cleared.
- States:
  - IDLE: no access issued.
  - G0: port 0 access issued this cycle.
  - G1: port 1 access issued this cycle.
- Transitions, decided at each rising edge from the registered req inputs:
  - From IDLE: req0 and req1 both high -> grant the port that is not last_grant. Only req0 high -> G0. Only req1 high -> G1. Neither -> IDLE.
  - From G0: req1 high -> G1; otherwise -> IDLE. Port 0 is masked for one cycle after its grant, so it is never double-granted while it drops req0.
  - From G1: symmetric to G0.
- Outputs in state Gi, all registered:
  - gnt_i=1, mem_ce=1, mem_we=we_i, mem_addr=addr_i, mem_wdata=wdata_i.
  - last_grant<=i.
- Outputs in IDLE: mem_ce=0, mem_we=0; mem_addr and mem_wdata hold their previous values.
- Latency:
  - req_i sampled high at edge t -> gnt_i and the memory access during cycle t+1.
  - For a read, rvalid_i=1 in cycle t+2 with rdata_i=mem_rdata.
  - Writes never raise rvalid.
  - rdata0 and rdata1 are combinational copies of mem_rdata; they are meaningful only while the matching rvalid is high.
- Requester rule: deassert req_i, or present the next access, in the cycle after gnt_i. Address and data must be stable from req_i high until gnt_i.
- Throughput:
  - Both ports requesting continuously -> strict alternation G0,G1,G0,G1 at 1 access per cycle.
  - A single port requesting continuously -> 1 access per 2 cycles (G,IDLE,G,...).
- At most one of gnt0/gnt1 is high in any cycle. At most one of rvalid0/rvalid1 is high in any cycle.
- Reset mid-operation: a rvalid due in the cycle after rst is suppressed. A granted access in progress is abandoned; mem_ce=0 from the first cycle after rst is sampled.

Optional Feature:
- Macro ARB_LOCK_EN adds inputs lock0 and lock1 (1 bit each) and makes each lock_i stable while req_i is high.
- Defined:
  - A grant to port i whose lock_i is high sets owner=i.
  - While owner=i and lock_i stays high, the other port is never granted. Port i still obeys its one-cycle mask.
  - owner clears on the first edge where lock_i is low. Clearing owner also happens on rst.
  - Use case: CPU/host read-modify-write without interleaving.
- Undefined: no lock ports, no owner register; pure round-robin as above.

Test Plan:
- Reset: assert rst for 2 cycles while req0=req1=1 -> gnt*, rvalid*, mem_ce, mem_we all 0; first grant after release goes to port 0.
- Single read: mem[0x10]=0xBEEF; req1=1, we1=0, addr1=0x10 at edge t -> gnt1=1 and mem_addr=0x10 in cycle t+1; rvalid1=1 and rdata1=0xBEEF in cycle t+2; rvalid0 stays 0.
- Write then read, port 0: write 0x1234 to 0x05, then read 0x05 -> mem_we=1 with mem_wdata=0x1234 on the write grant; the read returns 0x1234; no rvalid0 on the write.
- Contention: req0 and req1 held high for 8 cycles -> gnt sequence 0,1,0,1,...; never both high; the memory issues every cycle.
- Single-port streaming: req0 held high for 6 cycles -> gnt0 pattern 1,0,1,0,1,0; mem_ce follows the same pattern.
- Lock (ARB_LOCK_EN): lock0=1 with req0 held and req1=1 -> only port 0 granted (1,0,1,0); drop lock0 -> gnt1 issued within 2 cycles.

Source files
------------

// File: rtl/nano_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous-read memory between
// two req/gnt requesters. Define ARB_LOCK_EN to add lock0/lock1 ownership.
module nano_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
`ifdef ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester holds req_i with stable we/addr/wdata until the
  // cycle gnt_i pulses; that cycle is the memory access. It drops req_i or
  // presents its next access in the following cycle. Reads return with
  // rvalid_i one cycle after gnt_i.
  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t state, next_state;
  logic   last_grant;
  logic   r0, r1;

`ifdef ARB_LOCK_EN
  logic owner_vld, owner_id;
  logic hold0, hold1;

  // The locked owner shuts out the other port until it drops lock.
  assign hold0 = owner_vld && !owner_id && lock0;
  assign hold1 = owner_vld &&  owner_id && lock1;
  assign r0    = req0 && !hold1;
  assign r1    = req1 && !hold0;

  always_ff @(posedge ck) begin
    if (rst) begin
      owner_vld <= 1'b0;
      owner_id  <= 1'b0;
    end else if (next_state == G0 && lock0) begin
      owner_vld <= 1'b1;
      owner_id  <= 1'b0;
    end else if (next_state == G1 && lock1) begin
      owner_vld <= 1'b1;
      owner_id  <= 1'b1;
    end else if (owner_vld && !(owner_id ? lock1 : lock0)) begin
      owner_vld <= 1'b0;
    end
  end
`else
  assign r0 = req0;
  assign r1 = req1;
`endif

  // A port just granted is masked for one cycle so its held req is not
  // counted twice.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (r0 && r1)  next_state = last_grant ? G0 : G1;
        else if (r0)   next_state = G0;
        else if (r1)   next_state = G1;
      end
      G0:      next_state = r1 ? G1 : IDLE;
      G1:      next_state = r0 ? G0 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      state   <= next_state;
      rvalid0 <= (state == G0) && !mem_we;
      rvalid1 <= (state == G1) && !mem_we;
      case (next_state)
        G0: begin
          last_grant <= 1'b0;
          mem_we     <= we0;
          mem_addr   <= addr0;
          mem_wdata  <= wdata0;
        end
        G1: begin
          last_grant <= 1'b1;
          mem_we     <= we1;
          mem_addr   <= addr1;
          mem_wdata  <= wdata1;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  assign gnt0      = (state == G0);
  assign gnt1      = (state == G1);
  assign mem_ce    = (state != IDLE);
  assign rdata0    = mem_rdata;
  assign rdata1    = mem_rdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Directed bench for nano_mem_arbiter with a behavioural 256x16 memory and
// per-port read-data scoreboards.
module tb_nano_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_state;
`ifdef ARB_LOCK_EN
  logic          lock0 = 1'b0, lock1 = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  // clock/reset block
  always #5 ck = ~ck;

  nano_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .ck(ck), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always @(posedge ck) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard: pop expected read data whenever a port raises rvalid
  always @(negedge ck) begin
    if (mon_en) begin
      chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("rvalid_onehot", {31'd0, rvalid0 & rvalid1}, 32'd0);
      if (rvalid0) begin
        if (exp_q0.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
        else chk("rdata0", {16'd0, rdata0}, {16'd0, exp_q0.pop_front()});
      end
      if (rvalid1) begin
        if (exp_q1.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
        else chk("rdata1", {16'd0, rdata1}, {16'd0, exp_q1.pop_front()});
      end
    end
  end

  // driver: one access on port p from an idle arbiter
  task automatic do_single(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    int   lat;
    logic got;
    @(negedge ck);
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    if (we) ref_mem[a] = d;
    else if (p == 0) exp_q0.push_back(ref_mem[a]);
    else exp_q1.push_back(ref_mem[a]);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge ck);
      lat++;
      got = (p == 0) ? gnt0 : gnt1;
    end
    chk($sformatf("p%0d_gnt_latency", p), lat, 1);
    chk($sformatf("p%0d_other_gnt", p), {31'd0, (p == 0) ? gnt1 : gnt0}, 32'd0);
    chk($sformatf("p%0d_mem_ce", p), {31'd0, mem_ce}, 32'd1);
    chk($sformatf("p%0d_mem_we", p), {31'd0, mem_we}, {31'd0, we});
    chk($sformatf("p%0d_mem_addr", p), {24'd0, mem_addr}, {24'd0, a});
    if (we) chk($sformatf("p%0d_mem_wdata", p), {16'd0, mem_wdata}, {16'd0, d});
    @(negedge ck);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    chk($sformatf("p%0d_rvalid", p), {31'd0, (p == 0) ? rvalid0 : rvalid1}, {31'd0, !we});
  endtask

  initial begin
    // reset held with both ports requesting writes
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'hA0A0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h21; wdata1 = 16'hB1B1;
    for (int k = 0; k < 2; k++) begin
      @(negedge ck);
      chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("rst_mem", {30'd0, mem_we, mem_ce}, 32'd0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    ref_mem[8'h20] = 16'hA0A0;
    ref_mem[8'h21] = 16'hB1B1;

    // contention: strict alternation starting with port 0
    for (int k = 0; k < 8; k++) begin
      @(negedge ck);
      chk($sformatf("cont_gnt0_%0d", k), {31'd0, gnt0}, {31'd0, k % 2 == 0});
      chk($sformatf("cont_gnt1_%0d", k), {31'd0, gnt1}, {31'd0, k % 2 == 1});
      chk($sformatf("cont_ce_%0d", k), {31'd0, mem_ce}, 32'd1);
      chk($sformatf("cont_addr_%0d", k), {24'd0, mem_addr}, (k % 2 == 0) ? 32'h20 : 32'h21);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge ck);
    chk("cont_idle_ce", {31'd0, mem_ce}, 32'd0);

    // host download then single read, port 0 write/read, cross readback
    do_single(1, 1'b1, 8'h10, 16'hBEEF);
    do_single(1, 1'b0, 8'h10, 16'h0000);
    do_single(0, 1'b1, 8'h05, 16'h1234);
    do_single(0, 1'b0, 8'h05, 16'h0000);
    do_single(1, 1'b0, 8'h20, 16'h0000);
    do_single(0, 1'b0, 8'h21, 16'h0000);
    repeat (2) @(negedge ck);

    // single-port streaming reads
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    for (int k = 0; k < 3; k++) exp_q0.push_back(ref_mem[8'h05]);
    for (int k = 0; k < 6; k++) begin
      @(negedge ck);
      chk($sformatf("stream_gnt0_%0d", k), {31'd0, gnt0}, {31'd0, k % 2 == 0});
      chk($sformatf("stream_ce_%0d", k), {31'd0, mem_ce}, {31'd0, k % 2 == 0});
    end
    req0 = 1'b0;
    repeat (3) @(negedge ck);

    // reset during a granted read suppresses its rvalid
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    @(negedge ck);
    chk("midrst_gnt1", {31'd0, gnt1}, 32'd1);
    rst = 1'b1;
    req1 = 1'b0;
    @(negedge ck);
    chk("midrst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("midrst_ce", {31'd0, mem_ce}, 32'd0);
    chk("midrst_gnt1_off", {31'd0, gnt1}, 32'd0);
    rst = 1'b0;
    @(negedge ck);
    chk("midrst_after_ce", {31'd0, mem_ce}, 32'd0);

`ifdef ARB_LOCK_EN
    // port 0 locks out port 1 until it releases the lock
    lock0 = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 16'h3030;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h31; wdata1 = 16'h3131;
    for (int k = 0; k < 4; k++) begin
      @(negedge ck);
      chk($sformatf("lock_gnt0_%0d", k), {31'd0, gnt0}, {31'd0, k % 2 == 0});
      chk($sformatf("lock_gnt1_%0d", k), {31'd0, gnt1}, 32'd0);
    end
    lock0 = 1'b0;
    req0 = 1'b0;
    begin
      logic got;
      got = 1'b0;
      for (int k = 0; k < 2 && !got; k++) begin
        @(negedge ck);
        got = gnt1;
      end
      chk("lock_release_gnt1", {31'd0, got}, 32'd1);
    end
    req1 = 1'b0;
    ref_mem[8'h30] = 16'h3030;
    ref_mem[8'h31] = 16'h3131;
    repeat (2) @(negedge ck);
`endif

    repeat (3) @(negedge ck);
    chk("q0_drained", exp_q0.size(), 32'd0);
    chk("q1_drained", exp_q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
